// File: rtl/simd_dmem_ctrl_if.sv
// Port bundle for simd_dmem_ctrl: scalar lane port A, vector port B and the debug scan stream.
// The processor/debug consumer uses the master modport; the memory uses the slave modport.
interface simd_dmem_ctrl_if #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned LANE_W = 16,
    parameter int unsigned DEPTH  = 256
);
    localparam int unsigned VADDR_W = $clog2(DEPTH);
    localparam int unsigned AADDR_W = VADDR_W + $clog2(LANES);
    localparam int unsigned VEC_W   = LANES * LANE_W;

    logic               a_we;
    logic [AADDR_W-1:0] a_addr;
    logic [LANE_W-1:0]  a_wdata;
    logic [LANE_W-1:0]  a_rdata;

    logic               b_en;
    logic               b_we;
    logic [VADDR_W-1:0] b_addr;
    logic [VEC_W-1:0]   b_wdata;
    logic [VEC_W-1:0]   b_rdata;

    logic               dbg_start;
    logic               dbg_step;
    logic               dbg_busy;
    logic               dbg_valid;
    logic [VADDR_W-1:0] dbg_addr;
    logic [VEC_W-1:0]   dbg_data;

    modport master (
        output a_we, a_addr, a_wdata, b_en, b_we, b_addr, b_wdata, dbg_start, dbg_step,
        input  a_rdata, b_rdata, dbg_busy, dbg_valid, dbg_addr, dbg_data
    );

    modport slave (
        input  a_we, a_addr, a_wdata, b_en, b_we, b_addr, b_wdata, dbg_start, dbg_step,
        output a_rdata, b_rdata, dbg_busy, dbg_valid, dbg_addr, dbg_data
    );
endinterface

// File: rtl/simd_dmem_ctrl.sv
// Dual-port SIMD data memory (scalar lane port A, vector port B) with a debug scan engine.
// Optional macro DMEM_FWD_EN: same-cycle read-during-write returns new data instead of old.
module simd_dmem_ctrl #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned LANE_W = 16,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    simd_dmem_ctrl_if.slave       bus
);
    localparam int unsigned LANE_SEL_W = $clog2(LANES);
    localparam int unsigned VADDR_W    = $clog2(DEPTH);
    localparam int unsigned AADDR_W    = VADDR_W + LANE_SEL_W;

    typedef logic [LANES-1:0][LANE_W-1:0] vec_t;
    typedef enum logic [1:0] {S_IDLE, S_RD, S_SHOW} state_t;

    vec_t                  mem [DEPTH];

    logic [VADDR_W-1:0]    a_word;
    logic [LANE_SEL_W-1:0] a_lane;
    vec_t                  b_wvec;
    logic                  b_wr;
    logic                  b_rd;

    logic [LANE_W-1:0]     a_rd_c;
    logic [VADDR_W-1:0]    rd_addr_c;
    vec_t                  rd_word_c;

    state_t                state, state_nxt;
    logic [VADDR_W-1:0]    ptr, ptr_nxt;
    logic                  busy_q, busy_nxt;
    logic                  valid_q, valid_nxt;
    logic                  load_c;

    logic [LANE_W-1:0]     a_rdata_q;
    vec_t                  b_rdata_q;
    vec_t                  dbg_data_q;

    assign a_word = bus.a_addr[AADDR_W-1:LANE_SEL_W];
    assign a_lane = bus.a_addr[LANE_SEL_W-1:0];
    assign b_wvec = bus.b_wdata;
    assign b_wr   = bus.b_en & bus.b_we;
    assign b_rd   = bus.b_en & ~bus.b_we;

    // Storage: B writes the whole word first so A's lane wins on a same-word collision.
    always_ff @(posedge clk) begin
        if (b_wr) begin
            mem[bus.b_addr] <= b_wvec;
        end
        if (bus.a_we) begin
            mem[a_word][a_lane] <= bus.a_wdata;
        end
    end

    // Port A read data
    always_comb begin
        a_rd_c = mem[a_word][a_lane];
`ifdef DMEM_FWD_EN
        if (bus.a_we) begin
            a_rd_c = bus.a_wdata;
        end else if (b_wr && (bus.b_addr == a_word)) begin
            a_rd_c = b_wvec[a_lane];
        end
`endif
    end

    // Shared port-B read path: the processor owns it whenever b_en=1, the scanner otherwise.
    assign rd_addr_c = bus.b_en ? bus.b_addr : ptr;

    always_comb begin
        rd_word_c = mem[rd_addr_c];
`ifdef DMEM_FWD_EN
        if (bus.a_we && (a_word == rd_addr_c)) begin
            rd_word_c[a_lane] = bus.a_wdata;
        end
`endif
    end

    // Scan FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Scan FSM next-state and registered-output next values
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        busy_nxt  = busy_q;
        valid_nxt = valid_q;
        load_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.dbg_start) begin
                    state_nxt = S_RD;
                    ptr_nxt   = '0;
                    busy_nxt  = 1'b1;
                end
            end
            S_RD: begin
                if (!bus.b_en) begin
                    state_nxt = S_SHOW;
                    valid_nxt = 1'b1;
                    load_c    = 1'b1;
                end
            end
            S_SHOW: begin
                if (bus.dbg_step) begin
                    valid_nxt = 1'b0;
                    if (ptr == VADDR_W'(DEPTH - 1)) begin
                        state_nxt = S_IDLE;
                        busy_nxt  = 1'b0;
                    end else begin
                        ptr_nxt   = ptr + VADDR_W'(1);
                        state_nxt = S_RD;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                busy_nxt  = 1'b0;
                valid_nxt = 1'b0;
            end
        endcase
    end

    // Output and scan datapath registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr        <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            dbg_data_q <= '0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            ptr       <= ptr_nxt;
            busy_q    <= busy_nxt;
            valid_q   <= valid_nxt;
            a_rdata_q <= a_rd_c;
            if (b_rd) begin
                b_rdata_q <= rd_word_c;
            end
            if (load_c) begin
                dbg_data_q <= rd_word_c;
            end
        end
    end

    assign bus.a_rdata   = a_rdata_q;
    assign bus.b_rdata   = b_rdata_q;
    assign bus.dbg_busy  = busy_q;
    assign bus.dbg_valid = valid_q;
    assign bus.dbg_addr  = ptr;
    assign bus.dbg_data  = dbg_data_q;
endmodule

// File: tb/tb_simd_dmem_ctrl.sv
// Directed testbench for simd_dmem_ctrl: port A/B access, write collisions,
// read-during-write behaviour, full debug scan with processor stall, and mid-scan reset.
module tb_simd_dmem_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    simd_dmem_ctrl_if #(.LANES(16), .LANE_W(16), .DEPTH(256)) bus ();

    simd_dmem_ctrl #(.LANES(16), .LANE_W(16), .DEPTH(256)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] fill(input logic [15:0] v);
        return {16{v}};
    endfunction

    task automatic wait_valid();
        int n = 0;
        while (bus.dbg_valid !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check("valid_timeout", 256'(bus.dbg_valid), 256'd1);
    endtask

    logic [255:0] exp_v;

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        bus.a_we      = 1'b0;
        bus.a_addr    = '0;
        bus.a_wdata   = '0;
        bus.b_en      = 1'b0;
        bus.b_we      = 1'b0;
        bus.b_addr    = '0;
        bus.b_wdata   = '0;
        bus.dbg_start = 1'b0;
        bus.dbg_step  = 1'b0;
        tick();
        tick();

        check("rst_a_rdata",  256'(bus.a_rdata),   256'd0);
        check("rst_b_rdata",  bus.b_rdata,         256'd0);
        check("rst_busy",     256'(bus.dbg_busy),  256'd0);
        check("rst_valid",    256'(bus.dbg_valid), 256'd0);
        check("rst_addr",     256'(bus.dbg_addr),  256'd0);
        check("rst_data",     bus.dbg_data,        256'd0);
        reset = 1'b1;

        // Preload word i = i in every lane
        for (int w = 0; w < 256; w++) begin
            bus.b_en    = 1'b1;
            bus.b_we    = 1'b1;
            bus.b_addr  = 8'(w);
            bus.b_wdata = fill(16'(w));
            tick();
        end
        bus.b_en = 1'b0;
        bus.b_we = 1'b0;

        bus.a_addr = {8'd77, 4'd3};
        tick();
        check("a_read_basic", 256'(bus.a_rdata), 256'd77);

        // Full scan, with a 10-cycle processor stall at word 10 and an ignored start at word 20
        bus.dbg_start = 1'b1;
        tick();
        bus.dbg_start = 1'b0;
        check("scan_busy_start",  256'(bus.dbg_busy),  256'd1);
        check("scan_valid_start", 256'(bus.dbg_valid), 256'd0);
        for (int w = 0; w < 256; w++) begin
            if (w == 10) begin
                bus.b_en   = 1'b1;
                bus.b_we   = 1'b0;
                bus.b_addr = 8'd200;
                for (int k = 0; k < 10; k++) begin
                    tick();
                    check("stall_valid", 256'(bus.dbg_valid), 256'd0);
                    check("stall_addr",  256'(bus.dbg_addr),  256'd10);
                    check("stall_proc_read", bus.b_rdata, fill(16'd200));
                end
                bus.b_en = 1'b0;
            end
            wait_valid();
            check("scan_addr", 256'(bus.dbg_addr), 256'(w));
            check("scan_data", bus.dbg_data, fill(16'(w)));
            bus.dbg_step = 1'b1;
            if (w == 20) bus.dbg_start = 1'b1;
            tick();
            bus.dbg_step  = 1'b0;
            bus.dbg_start = 1'b0;
            check("step_valid", 256'(bus.dbg_valid), 256'd0);
            check("step_busy",  256'(bus.dbg_busy), (w == 255) ? 256'd0 : 256'd1);
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            check("no_extra_valid", 256'(bus.dbg_valid), 256'd0);
            check("no_extra_busy",  256'(bus.dbg_busy),  256'd0);
        end

        // Scalar write then vector read of word 3
        bus.a_we    = 1'b1;
        bus.a_addr  = {8'd3, 4'd2};
        bus.a_wdata = 16'hBEEF;
        tick();
        bus.a_we   = 1'b0;
        bus.b_en   = 1'b1;
        bus.b_we   = 1'b0;
        bus.b_addr = 8'd3;
        tick();
        bus.b_en = 1'b0;
        exp_v = fill(16'h0003);
        exp_v[47:32] = 16'hBEEF;
        check("t1_b_word3",  bus.b_rdata, exp_v);
        check("t1_a_lane2",  256'(bus.a_rdata), 256'h0000_BEEF);

        // Same-word collision: A's lane overrides B's full-word write
        bus.b_en    = 1'b1;
        bus.b_we    = 1'b1;
        bus.b_addr  = 8'd5;
        bus.b_wdata = fill(16'h1111);
        bus.a_we    = 1'b1;
        bus.a_addr  = {8'd5, 4'd0};
        bus.a_wdata = 16'h2222;
        tick();
        bus.a_we = 1'b0;
        bus.b_we = 1'b0;
        tick();
        bus.b_en = 1'b0;
        exp_v = fill(16'h1111);
        exp_v[15:0] = 16'h2222;
        check("t2_collision_word", bus.b_rdata, exp_v);
        bus.a_addr = {8'd5, 4'd1};
        tick();
        check("t2_collision_lane1", 256'(bus.a_rdata), 256'h1111);

        // Read-during-write across ports on word 7
        bus.b_en    = 1'b1;
        bus.b_we    = 1'b1;
        bus.b_addr  = 8'd7;
        bus.b_wdata = fill(16'hAAAA);
        tick();
        bus.b_wdata = fill(16'h5555);
        bus.a_addr  = {8'd7, 4'd0};
        tick();
`ifdef DMEM_FWD_EN
        check("t3_a_rdw", 256'(bus.a_rdata), 256'h5555);
`else
        check("t3_a_rdw", 256'(bus.a_rdata), 256'hAAAA);
`endif
        bus.b_we    = 1'b0;
        bus.a_we    = 1'b1;
        bus.a_addr  = {8'd7, 4'd1};
        bus.a_wdata = 16'h1234;
        tick();
        bus.a_we = 1'b0;
        exp_v = fill(16'h5555);
`ifdef DMEM_FWD_EN
        exp_v[31:16] = 16'h1234;
        check("t3_a_self_rdw", 256'(bus.a_rdata), 256'h1234);
`else
        check("t3_a_self_rdw", 256'(bus.a_rdata), 256'h5555);
`endif
        check("t3_b_rdw", bus.b_rdata, exp_v);
        tick();
        bus.b_en = 1'b0;
        exp_v = fill(16'h5555);
        exp_v[31:16] = 16'h1234;
        check("t3_b_after", bus.b_rdata, exp_v);

        // Reset while showing word 40
        bus.dbg_start = 1'b1;
        tick();
        bus.dbg_start = 1'b0;
        for (int w = 0; w < 40; w++) begin
            wait_valid();
            bus.dbg_step = 1'b1;
            tick();
            bus.dbg_step = 1'b0;
        end
        wait_valid();
        check("t6_show_addr", 256'(bus.dbg_addr), 256'd40);
        check("t6_show_data", bus.dbg_data, fill(16'd40));
        reset = 1'b0;
        tick();
        check("t6_busy",    256'(bus.dbg_busy),  256'd0);
        check("t6_valid",   256'(bus.dbg_valid), 256'd0);
        check("t6_data",    bus.dbg_data,        256'd0);
        check("t6_addr",    256'(bus.dbg_addr),  256'd0);
        check("t6_a_rdata", 256'(bus.a_rdata),   256'd0);
        check("t6_b_rdata", bus.b_rdata,         256'd0);
        reset = 1'b1;
        tick();
        check("t6_idle_valid", 256'(bus.dbg_valid), 256'd0);
        bus.b_en   = 1'b1;
        bus.b_we   = 1'b0;
        bus.b_addr = 8'd40;
        bus.a_addr = {8'd40, 4'd9};
        tick();
        bus.b_en = 1'b0;
        check("t6_mem_b", bus.b_rdata, fill(16'd40));
        check("t6_mem_a", 256'(bus.a_rdata), 256'd40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
